// File: rtl/branch_compare_unit_if.sv
// Request/response bundle between the branch compare unit and its issue/consumer stages.
// The unit's pipeline counter width is carried here so both sides agree on it.
interface branch_compare_unit_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       cond_select;
    logic             is_branch;
    logic             pred_taken;
    logic             Z;
    logic             N;
    logic             V;
    logic             C;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             condition_result;
    logic             branch_taken;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output in_valid, cond_select, is_branch, pred_taken, Z, N, V, C, pc, imm,
        output flush, out_ready,
        input  in_ready, out_valid, condition_result, branch_taken, redirect,
        input  redirect_pc, mispredict_count
    );

    modport slave (
        input  in_valid, cond_select, is_branch, pred_taken, Z, N, V, C, pc, imm,
        input  flush, out_ready,
        output in_ready, out_valid, condition_result, branch_taken, redirect,
        output redirect_pc, mispredict_count
    );
endinterface

// File: rtl/branch_compare_unit.sv
// Resolves branch / set-less-than conditions from ALU flags, detects mispredictions
// and presents a one-deep registered response with a saturating mispredict counter.
module branch_compare_unit #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_compare_unit_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // funct3 condition decode; SLT/SLTU reuse the BLT/BLTU encodings.
    function automatic logic eval_cond(
        input logic [2:0] sel,
        input logic       z,
        input logic       n,
        input logic       v,
        input logic       c
    );
        logic r;
        case (sel)
            3'b000:  r = z;
            3'b001:  r = ~z;
            3'b010:  r = n ^ v;
            3'b011:  r = ~c;
            3'b100:  r = n ^ v;
            3'b101:  r = ~(n ^ v);
            3'b110:  r = ~c;
            3'b111:  r = c;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic             out_valid_r;
    logic             cond_r;
    logic             taken_r;
    logic             redirect_r;
    logic [31:0]      target_r;
    logic [CNT_W-1:0] count_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             deliver_s;
    logic             cond_s;
    logic             taken_s;
    logic             redirect_s;
    logic [31:0]      target_s;

    assign in_ready_s = ~bus.flush & (~out_valid_r | bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;
    assign deliver_s  = out_valid_r & bus.out_ready & ~bus.flush;

    // Response computed from the presented request, registered only on accept.
    always_comb begin
        cond_s     = eval_cond(bus.cond_select, bus.Z, bus.N, bus.V, bus.C);
        taken_s    = bus.is_branch & cond_s;
        redirect_s = bus.is_branch & (taken_s != bus.pred_taken);
        if (!bus.is_branch) begin
            target_s = 32'd0;
        end else if (taken_s) begin
            target_s = bus.pc + bus.imm;
        end else begin
            target_s = bus.pc + 32'd4;
        end
    end

    // Output valid flag: flush dominates, then load, then drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Response data fields; untouched when draining so the last result stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_r     <= 1'b0;
            taken_r    <= 1'b0;
            redirect_r <= 1'b0;
            target_r   <= 32'd0;
        end else if (accept_s) begin
            cond_r     <= cond_s;
            taken_r    <= taken_s;
            redirect_r <= redirect_s;
            target_r   <= target_s;
        end else begin
            cond_r     <= cond_r;
            taken_r    <= taken_r;
            redirect_r <= redirect_r;
            target_r   <= target_r;
        end
    end

    // Mispredict counter counts only redirects actually handed to fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (deliver_s && redirect_r && (count_r != CNT_MAX)) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign bus.in_ready         = in_ready_s;
    assign bus.out_valid        = out_valid_r;
    assign bus.condition_result = cond_r;
    assign bus.branch_taken     = taken_r;
    assign bus.redirect         = redirect_r;
    assign bus.redirect_pc      = target_r;
    assign bus.mispredict_count = count_r;
endmodule

// File: tb/tb_branch_compare_unit.sv
// Directed-vector bench: expected responses queue on acceptance, a negedge monitor
// pops and compares on every handshake, flush or hold cycle.
module tb_branch_compare_unit;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = 3;

    typedef struct packed {
        logic        cr;
        logic        bt;
        logic        rd;
        logic [31:0] rpc;
    } resp_t;

    typedef struct packed {
        logic [2:0]  cond;
        logic        br;
        logic        pred;
        logic        z;
        logic        n;
        logic        v;
        logic        c;
        logic [31:0] pc;
        logic [31:0] imm;
        resp_t       exp;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic rst_seen;
    int   exp_cnt;
    resp_t last;
    resp_t pend;
    resp_t q[$];

    branch_compare_unit_if #(.CNT_W(CNT_W)) bus ();

    branch_compare_unit #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs[8];
    initial begin
        //          cond    br    pred  z     n     v     c     pc            imm           cr    bt    rd    rpc
        vecs[0] = '{3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000100, 32'h00000020, '{1'b1, 1'b1, 1'b1, 32'h00000120}};
        vecs[1] = '{3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h00000040, '{1'b0, 1'b0, 1'b0, 32'h00000000}};
        vecs[2] = '{3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000500, 32'h00000010, '{1'b1, 1'b0, 1'b0, 32'h00000000}};
        vecs[3] = '{3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00002000, 32'hFFFFFFF0, '{1'b1, 1'b1, 1'b0, 32'h00001FF0}};
        vecs[4] = '{3'b101, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00003000, 32'h00000100, '{1'b0, 1'b0, 1'b1, 32'h00003004}};
        vecs[5] = '{3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00004000, 32'h00000008, '{1'b1, 1'b1, 1'b1, 32'h00004008}};
        vecs[6] = '{3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00006000, 32'h00000004, '{1'b1, 1'b0, 1'b0, 32'h00000000}};
        vecs[7] = '{3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000010, 32'h00000010, '{1'b1, 1'b1, 1'b0, 32'h00000020}};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_resp(input string tag, input resp_t req);
        chk({tag, ".condition_result"}, {31'd0, bus.condition_result}, {31'd0, req.cr});
        chk({tag, ".branch_taken"}, {31'd0, bus.branch_taken}, {31'd0, req.bt});
        chk({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, req.rd});
        chk({tag, ".redirect_pc"}, bus.redirect_pc, req.rpc);
    endtask

    always @(posedge rst) rst_seen = 1'b1;

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic mr;
        if (rst || rst_seen) begin
            q.delete();
            exp_cnt  = 0;
            last     = '0;
            rst_seen = 1'b0;
        end
        if (rst) begin
            chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("reset.count", {30'd0, bus.mispredict_count}, 32'd0);
            chk_resp("reset", '0);
        end else begin
            mr = !bus.flush && (q.size() == 0 || bus.out_ready);
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, mr});
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (q.size() != 0)});
            chk("mispredict_count", {30'd0, bus.mispredict_count}, exp_cnt);
            if (q.size() != 0) begin
                chk_resp("resp", q[0]);
                if (bus.flush) begin
                    last = q.pop_front();
                end else if (bus.out_ready) begin
                    if (q[0].rd && exp_cnt != CNT_MAX) exp_cnt++;
                    last = q.pop_front();
                end
            end else begin
                chk_resp("idle_hold", last);
            end
            if (bus.in_valid && mr) q.push_back(pend);
        end
    end

    task automatic apply(input vec_t v);
        bus.cond_select = v.cond;
        bus.is_branch   = v.br;
        bus.pred_taken  = v.pred;
        bus.Z           = v.z;
        bus.N           = v.n;
        bus.V           = v.v;
        bus.C           = v.c;
        bus.pc          = v.pc;
        bus.imm         = v.imm;
        pend            = v.exp;
        bus.in_valid    = 1'b1;
    endtask

    // Presents one request and holds it until the unit takes it.
    task automatic issue(input vec_t v);
        logic acc;
        int   n;
        apply(v);
        n = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                acc = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk({tag, ".async_count"}, {30'd0, bus.mispredict_count}, 32'd0);
        chk({tag, ".async_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, ".async_redirect_pc"}, bus.redirect_pc, 32'd0);
        #2 rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_seen = 1'b0;
        exp_cnt = 0;
        last = '0;
        pend = '0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush = 1'b0;
        bus.cond_select = 3'd0;
        bus.is_branch = 1'b0;
        bus.pred_taken = 1'b0;
        bus.Z = 1'b0;
        bus.N = 1'b0;
        bus.V = 1'b0;
        bus.C = 1'b0;
        bus.pc = 32'd0;
        bus.imm = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // All condition codes, back to back.
        for (int i = 0; i < 8; i++) issue(vecs[i]);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: a second request waits three cycles behind a held response.
        bus.out_ready = 1'b0;
        issue(vecs[0]);
        apply(vecs[1]);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        issue(vecs[1]);
        issue(vecs[2]);
        issue(vecs[3]);
        repeat (3) @(posedge clk);
        #1;

        // Flush while a redirect is being handed off, with a competing request.
        bus.out_ready = 1'b0;
        issue(vecs[0]);
        apply(vecs[4]);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset with a response pending, then saturate the counter.
        bus.out_ready = 1'b0;
        issue(vecs[5]);
        async_reset_check("pending");
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        issue(vecs[0]);
        issue(vecs[4]);
        issue(vecs[5]);
        issue(vecs[0]);
        issue(vecs[4]);
        repeat (3) @(posedge clk);
        #1;
        chk("saturated_count", {30'd0, bus.mispredict_count}, 32'd3);
        async_reset_check("saturated");
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
